dac_serial_driver: RTL and testbench

Parametrised serial-DAC write engine. It is the successor to the team's fixed 12-bit single-DAC driver: it drives NUM_CH DACs that share CS/SCLK/LD/CLR, each DAC on its own SDI line. Words are accepted through a valid/ready handshake and captured once per frame. It adds a programmable SCLK rate, an optional per-frame load strobe, and a queued clear command. It sits between sample-generation logic and the DAC pins.

---
 rtl/dac_serial_pkg.sv | 27 ++
 rtl/dac_bit_timer.sv | 49 ++++
 rtl/dac_serial_driver.sv | 169 ++++++++++++++++
 tb/tb_dac_serial_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_serial_pkg.sv
// Shared types and constants for the serial DAC write engine.
package dac_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_LOAD,
    ST_CLEAR
  } state_t;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_NUM_CH = 1;
  localparam int DEF_HALF   = 2;
  localparam int DEF_LD_GAP = 1;
  localparam int DEF_LD_W   = 2;
  localparam int DEF_CLR_W  = 2;

  // Counter width for values 0..v-1, never below one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dac_bit_timer.sv
// SCLK half-period prescaler and bit counter for one shift frame.
module dac_bit_timer
  import dac_serial_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HALF   = DEF_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic phase,
  output logic half_end,
  output logic bit_last,
  output logic shift_en
);

  localparam int HW = clog2(HALF);
  localparam int BW = clog2(DATA_W);

  logic [HW-1:0] pre;
  logic [BW-1:0] bit_cnt;

  assign half_end = (pre == HW'(HALF - 1));
  assign bit_last = (bit_cnt == BW'(DATA_W - 1));
  // End of a high phase that is followed by another bit.
  assign shift_en = run & half_end & phase & ~bit_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (start) begin
      pre     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (run) begin
      if (half_end) begin
        pre   <= '0;
        phase <= ~phase;
        if (phase) bit_cnt <= bit_cnt + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_serial_driver.sv
// Multi-channel serial DAC write engine: shared CS/SCLK/LD/CLR, one SDI per DAC.
module dac_serial_driver
  import dac_serial_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int HALF   = DEF_HALF,
  parameter int LD_GAP = DEF_LD_GAP,
  parameter int LD_W   = DEF_LD_W,
  parameter int CLR_W  = DEF_CLR_W
) (
  input  logic                     clk_50M,
  input  logic                     locked,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic                     din_load,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     done,
  output logic                     dac_cs_n,
  output logic                     dac_sclk,
  output logic [NUM_CH-1:0]        dac_sdi,
  output logic                     dac_ld_n,
  output logic                     dac_clr_n
);

  if (DATA_W < 1 || DATA_W > 32 || NUM_CH < 1 || NUM_CH > 8 || HALF < 1 ||
      LD_GAP < 0 || LD_W < 1 || CLR_W < 1) begin : g_param_err
    $error("dac_serial_driver: parameter out of range");
  end

  localparam int CMAX = (LD_GAP > LD_W) ? ((LD_GAP > CLR_W) ? LD_GAP : CLR_W)
                                        : ((LD_W > CLR_W) ? LD_W : CLR_W);
  localparam int CW   = clog2(CMAX + 1);

  state_t                        state;
  logic                          clr_pend;
  logic                          ld_mode;
  logic [NUM_CH-1:0][DATA_W-1:0] sh;
  logic [NUM_CH-1:0][DATA_W-1:0] sh_nx;
  logic [CW-1:0]                 cnt;
  logic                          run;
  logic                          phase;
  logic                          half_end;
  logic                          bit_last;
  logic                          shift_en;
  logic                          start;

  // Handshake: a word transfers on a cycle with din_valid & din_ready; the
  // source holds din stable while valid is high and not yet accepted.
  // A pending or same-cycle clear withholds ready so the word stays offered.
  assign din_ready = (state == ST_IDLE) & ~clr_pend & ~clr_req;
  assign start     = din_valid & din_ready;
  assign run       = (state == ST_SHIFT);

  always_comb begin
    sh_nx = sh;
    for (int c = 0; c < NUM_CH; c++) sh_nx[c] = sh[c] << 1;
  end

  dac_bit_timer #(
    .DATA_W (DATA_W),
    .HALF   (HALF)
  ) u_timer (
    .clk      (clk_50M),
    .rst_n    (locked),
    .start    (start),
    .run      (run),
    .phase    (phase),
    .half_end (half_end),
    .bit_last (bit_last),
    .shift_en (shift_en)
  );

  always_ff @(posedge clk_50M or negedge locked) begin
    if (!locked) begin
      state     <= ST_IDLE;
      clr_pend  <= 1'b0;
      ld_mode   <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dac_cs_n  <= 1'b1;
      dac_sclk  <= 1'b1;
      dac_sdi   <= '0;
      dac_ld_n  <= 1'b1;
      dac_clr_n <= 1'b1;
    end else begin
      done <= 1'b0;
      if (clr_req && state != ST_IDLE) clr_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (clr_req || clr_pend) begin
            state     <= ST_CLEAR;
            clr_pend  <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            dac_clr_n <= 1'b0;
          end else if (start) begin
            state    <= ST_SHIFT;
            busy     <= 1'b1;
            ld_mode  <= din_load;
            dac_cs_n <= 1'b0;
            dac_sclk <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
              sh[c]      <= din[c*DATA_W +: DATA_W];
              dac_sdi[c] <= din[c*DATA_W + DATA_W - 1];
            end
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            dac_sclk <= 1'b0;
            sh       <= sh_nx;
            for (int c = 0; c < NUM_CH; c++) dac_sdi[c] <= sh_nx[c][DATA_W-1];
          end else if (half_end && !phase) begin
            dac_sclk <= 1'b1;
          end else if (half_end && bit_last) begin
            dac_cs_n <= 1'b1;
            dac_sdi  <= '0;
            cnt      <= '0;
            if (!ld_mode) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (LD_GAP == 0) begin
              state    <= ST_LOAD;
              dac_ld_n <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cnt == CW'(LD_GAP - 1)) begin
            state    <= ST_LOAD;
            cnt      <= '0;
            dac_ld_n <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          if (cnt == CW'(LD_W - 1)) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            dac_ld_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt == CW'(CLR_W - 1)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            dac_clr_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_driver.sv
// Directed bench for dac_serial_driver: default, two-channel and slow/wide instances.
module tb_dac_serial_driver;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic locked;

  logic [11:0] din_a;
  logic        din_load_a, din_valid_a, clr_req_a;
  logic        din_ready_a, busy_a, done_a, cs_n_a, sclk_a, ld_n_a, clr_n_a;
  logic [0:0]  sdi_a;

  logic [23:0] din_b;
  logic        din_load_b, din_valid_b, clr_req_b;
  logic        din_ready_b, busy_b, done_b, cs_n_b, sclk_b, ld_n_b, clr_n_b;
  logic [1:0]  sdi_b;

  logic [15:0] din_c;
  logic        din_load_c, din_valid_c, clr_req_c;
  logic        din_ready_c, busy_c, done_c, cs_n_c, sclk_c, ld_n_c, clr_n_c;
  logic [0:0]  sdi_c;

  logic [0:0] exp_q_a[$];
  logic [1:0] exp_q_b[$];
  logic [0:0] exp_q_c[$];

  int n_cmp = 0;
  int n_err = 0;

  dac_serial_driver u_dut_a (
    .clk_50M(clk), .locked(locked), .din(din_a), .din_load(din_load_a),
    .din_valid(din_valid_a), .din_ready(din_ready_a), .clr_req(clr_req_a),
    .busy(busy_a), .done(done_a), .dac_cs_n(cs_n_a), .dac_sclk(sclk_a),
    .dac_sdi(sdi_a), .dac_ld_n(ld_n_a), .dac_clr_n(clr_n_a)
  );

  dac_serial_driver #(.NUM_CH(2)) u_dut_b (
    .clk_50M(clk), .locked(locked), .din(din_b), .din_load(din_load_b),
    .din_valid(din_valid_b), .din_ready(din_ready_b), .clr_req(clr_req_b),
    .busy(busy_b), .done(done_b), .dac_cs_n(cs_n_b), .dac_sclk(sclk_b),
    .dac_sdi(sdi_b), .dac_ld_n(ld_n_b), .dac_clr_n(clr_n_b)
  );

  dac_serial_driver #(.DATA_W(16), .HALF(5)) u_dut_c (
    .clk_50M(clk), .locked(locked), .din(din_c), .din_load(din_load_c),
    .din_valid(din_valid_c), .din_ready(din_ready_c), .clr_req(clr_req_c),
    .busy(busy_c), .done(done_c), .dac_cs_n(cs_n_c), .dac_sclk(sclk_c),
    .dac_sdi(sdi_c), .dac_ld_n(ld_n_c), .dac_clr_n(clr_n_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_sclk(input int t, input int half, input int shifts);
    return (t <= shifts && ((t - 1) % (2 * half)) < half) ? 1'b0 : 1'b1;
  endfunction

  task automatic push_a(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) exp_q_a.push_back(w[i]);
  endtask

  task automatic start_a(input logic [11:0] w, input logic ld, input bit hold);
    din_a = w; din_load_a = ld; din_valid_a = 1'b1;
    push_a(w);
    #1 chk("ready_a", din_ready_a, 1);
    @(negedge clk);
    din_valid_a = hold;
  endtask

  // Walk a default-timing frame from cycle 1 to its done cycle.
  task automatic frame_a(input bit ld);
    int last;
    last = ld ? 52 : 49;
    for (int t = 1; t <= last; t++) begin
      chk("cs_a", cs_n_a, (t <= 48) ? 0 : 1);
      chk("sclk_a", sclk_a, exp_sclk(t, 2, 48));
      chk("ld_a", ld_n_a, (ld && (t == 50 || t == 51)) ? 0 : 1);
      chk("done_a", done_a, (t == last) ? 1 : 0);
      chk("clr_a", clr_n_a, 1);
      if (t == last) begin
        chk("ready_end_a", din_ready_a, 1);
        chk("busy_end_a", busy_a, 0);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle_a(input int lim);
    int k;
    k = 0;
    while (busy_a && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout_a", busy_a, 0);
  endtask

  // Scoreboard: each SCLK rise pops the next expected SDI value.
  logic pa = 1'b1, pb = 1'b1, pc = 1'b1;
  always @(negedge clk) begin
    if (locked && sclk_a && !pa) begin
      if (exp_q_a.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL sdi_a_extra: observed rise %0h expected none", sdi_a);
      end else chk("sdi_a", sdi_a, exp_q_a.pop_front());
    end
    if (locked && sclk_b && !pb) begin
      if (exp_q_b.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL sdi_b_extra: observed rise %0h expected none", sdi_b);
      end else chk("sdi_b", sdi_b, exp_q_b.pop_front());
    end
    if (locked && sclk_c && !pc) begin
      if (exp_q_c.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL sdi_c_extra: observed rise %0h expected none", sdi_c);
      end else chk("sdi_c", sdi_c, exp_q_c.pop_front());
    end
    pa = sclk_a;
    pb = sclk_b;
    pc = sclk_c;
  end

  initial begin
    locked = 1'b0;
    din_a = '0; din_load_a = 0; din_valid_a = 0; clr_req_a = 0;
    din_b = '0; din_load_b = 0; din_valid_b = 0; clr_req_b = 0;
    din_c = '0; din_load_c = 0; din_valid_c = 0; clr_req_c = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_n_a, 1);
    chk("rst_sclk", sclk_a, 1);
    chk("rst_sdi", sdi_a, 0);
    chk("rst_ld", ld_n_a, 1);
    chk("rst_clr", clr_n_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sdi_b", sdi_b, 0);
    locked = 1'b1;
    @(negedge clk);

    // Single-channel frame with load strobe.
    start_a(12'hA5C, 1'b1, 1'b0);
    frame_a(1'b1);
    @(negedge clk);

    // Shift-only frame with a second word held valid.
    start_a(12'h3C7, 1'b0, 1'b1);
    din_a = 12'h81E;
    push_a(12'h81E);
    frame_a(1'b0);
    @(negedge clk);
    chk("b2b_cs_a", cs_n_a, 0);
    din_valid_a = 1'b0;
    wait_idle_a(100);

    // Clear requested mid-frame, next word offered during the frame.
    start_a(12'h5A3, 1'b1, 1'b0);
    for (int t = 1; t <= 56; t++) begin
      chk("clrf_cs", cs_n_a, (t <= 48 || t == 56) ? 0 : 1);
      chk("clrf_ld", ld_n_a, (t == 50 || t == 51) ? 0 : 1);
      chk("clrf_clr", clr_n_a, (t == 53 || t == 54) ? 0 : 1);
      chk("clrf_done", done_a, (t == 52) ? 1 : 0);
      if (t == 52) chk("clrf_ready52", din_ready_a, 0);
      if (t == 55) begin
        chk("clrf_ready55", din_ready_a, 1);
        chk("clrf_busy55", busy_a, 0);
      end
      if (t == 20) clr_req_a = 1'b1;
      if (t == 21) clr_req_a = 1'b0;
      if (t == 30) begin
        din_a = 12'h0F1; din_load_a = 1'b0; din_valid_a = 1'b1;
        push_a(12'h0F1);
      end
      if (t == 56) din_valid_a = 1'b0;
      if (t < 56) @(negedge clk);
    end
    wait_idle_a(100);
    @(negedge clk);

    // Clear and word offered in the same idle cycle.
    clr_req_a = 1'b1; din_a = 12'hC33; din_load_a = 1'b1; din_valid_a = 1'b1;
    #1 chk("same_ready", din_ready_a, 0);
    @(negedge clk);
    clr_req_a = 1'b0;
    chk("same_clr1", clr_n_a, 0);
    chk("same_cs1", cs_n_a, 1);
    chk("same_busy1", busy_a, 1);
    @(negedge clk);
    chk("same_clr2", clr_n_a, 0);
    @(negedge clk);
    chk("same_clr3", clr_n_a, 1);
    chk("same_done3", done_a, 0);
    chk("same_ready3", din_ready_a, 1);
    push_a(12'hC33);
    @(negedge clk);
    chk("same_cs4", cs_n_a, 0);
    din_valid_a = 1'b0;
    wait_idle_a(100);
    @(negedge clk);

    // Reset in the middle of a frame.
    start_a(12'h9E4, 1'b1, 1'b0);
    repeat (29) @(negedge clk);
    #2 locked = 1'b0;
    #1;
    chk("abort_cs", cs_n_a, 1);
    chk("abort_sclk", sclk_a, 1);
    chk("abort_sdi", sdi_a, 0);
    chk("abort_ld", ld_n_a, 1);
    chk("abort_busy", busy_a, 0);
    exp_q_a.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_ld_hold", ld_n_a, 1);
      chk("abort_done_hold", done_a, 0);
    end
    locked = 1'b1;
    start_a(12'h6B2, 1'b1, 1'b0);
    frame_a(1'b1);
    @(negedge clk);

    // Two channels: ch0 all ones, ch1 all zeros.
    din_b = {12'h000, 12'hFFF}; din_load_b = 1'b1; din_valid_b = 1'b1;
    for (int i = 0; i < 12; i++) exp_q_b.push_back(2'b01);
    #1 chk("ready_b", din_ready_b, 1);
    @(negedge clk);
    din_valid_b = 1'b0;
    for (int t = 1; t <= 52; t++) begin
      chk("cs_b", cs_n_b, (t <= 48) ? 0 : 1);
      chk("sclk_b", sclk_b, exp_sclk(t, 2, 48));
      chk("ld_b", ld_n_b, (t == 50 || t == 51) ? 0 : 1);
      chk("done_b", done_b, (t == 52) ? 1 : 0);
      if (t < 52) @(negedge clk);
    end
    @(negedge clk);

    // 16-bit word, HALF=5, data toggled mid-frame.
    din_c = 16'hC3A5; din_load_c = 1'b1; din_valid_c = 1'b1;
    for (int i = 15; i >= 0; i--) exp_q_c.push_back(din_c[i]);
    #1 chk("ready_c", din_ready_c, 1);
    @(negedge clk);
    din_valid_c = 1'b0;
    for (int t = 1; t <= 164; t++) begin
      chk("cs_c", cs_n_c, (t <= 160) ? 0 : 1);
      chk("sclk_c", sclk_c, exp_sclk(t, 5, 160));
      chk("ld_c", ld_n_c, (t == 162 || t == 163) ? 0 : 1);
      chk("done_c", done_c, (t == 164) ? 1 : 0);
      if (t == 40) din_c = ~din_c;
      if (t < 164) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("q_a_empty", exp_q_a.size(), 0);
    chk("q_b_empty", exp_q_b.size(), 0);
    chk("q_c_empty", exp_q_c.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
